// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key-schedule blocks: word/key types,
// round constants, RotWord and the inverse key generator state encoding.
package aes_pkg;

  typedef logic [31:0] aes_word;
  // Packed so that word 0 lands in bits [127:96] of the flat 128-bit view.
  typedef aes_word [0:3] key_128;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_EMIT,
    ST_DONE
  } kg_state_e;

  function automatic aes_word rot_word(input aes_word w);
    return {w[23:0], w[31:24]};
  endfunction

  // Out-of-range indices occur only in states that discard the result.
  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    return (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_inv_key_gen_if.sv
// Start/key request plus valid/ready round-key stream of the inverse
// key-schedule generator. master = key register file / inverse datapath side.
interface aes_inv_key_gen_if
  import aes_pkg::*;
();
  logic       start_i;
  key_128     key_i;
  logic       key_is_last_i;
  logic       busy_o;
  logic       rk_valid_o;
  logic       rk_ready_i;
  key_128     rk_o;
  logic [3:0] rk_rnd_o;
  logic       done_o;

  modport master (
    output start_i, key_i, key_is_last_i, rk_ready_i,
    input  busy_o, rk_valid_o, rk_o, rk_rnd_o, done_o
  );

  modport slave (
    input  start_i, key_i, key_is_last_i, rk_ready_i,
    output busy_o, rk_valid_o, rk_o, rk_rnd_o, done_o
  );
endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box computed as GF(2^8) inversion (x^254) plus the affine map.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero as required.
  always_comb begin
    sq  = gf_mul(in_i, in_i);
    inv = sq;
    for (int k = 2; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: S-box applied independently to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word word_i,
  output aes_word word_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (word_i[8*gi +: 8]),
      .out_o (word_o[8*gi +: 8])
    );
  end

endmodule

// File: rtl/aes_inv_key_gen.sv
// Inverse AES-128 key schedule: optionally expands the cipher key to round 10,
// then streams round keys 10..0 over a valid/ready handshake.
module aes_inv_key_gen
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic               clk,
  input  logic               nrst,
  aes_inv_key_gen_if.slave   kg
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  kg_state_e  state_q, state_d;
  key_128     key_q, key_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rk_valid_q, rk_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  aes_word    w3_new, sw_in, sw_out, rc_word;
  aes_word    f0, f1, f2, f3;
  logic [3:0] rc_idx;
  logic       hs;

  // One SubWord serves both directions; FWD and EMIT never overlap.
  assign w3_new = key_q[3] ^ key_q[2];
  assign sw_in  = (state_q == ST_FWD) ? rot_word(key_q[3]) : rot_word(w3_new);

  aes_sub_word u_sub_word (
    .word_i (sw_in),
    .word_o (sw_out)
  );

  assign rc_idx  = (state_q == ST_FWD) ? cnt_q - 4'd1 : rnd_q - 4'd1;
  assign rc_word = {rcon_byte(rc_idx), 24'h000000};

  assign f0 = key_q[0] ^ sw_out ^ rc_word;
  assign f1 = key_q[1] ^ f0;
  assign f2 = key_q[2] ^ f1;
  assign f3 = key_q[3] ^ f2;

  assign hs = rk_valid_q & kg.rk_ready_i;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    rnd_d      = rnd_q;
    cnt_d      = cnt_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kg.start_i) begin
          key_d  = kg.key_i;
          busy_d = 1'b1;
          if (kg.key_is_last_i) begin
            state_d    = ST_EMIT;
            rnd_d      = LAST_RND;
            rk_valid_d = 1'b1;
          end else begin
            state_d = ST_FWD;
            cnt_d   = 4'd1;
          end
        end
      end
      ST_FWD: begin
        key_d = {f0, f1, f2, f3};
        if (cnt_q == LAST_RND) begin
          state_d    = ST_EMIT;
          rnd_d      = LAST_RND;
          cnt_d      = 4'd0;
          rk_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_EMIT: begin
        if (hs) begin
          if (rnd_q != 4'd0) begin
            key_d = {key_q[0] ^ sw_out ^ rc_word, key_q[1] ^ key_q[0],
                     key_q[2] ^ key_q[1], w3_new};
            rnd_d = rnd_q - 4'd1;
          end else begin
            state_d    = ST_DONE;
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      rnd_q      <= '0;
      cnt_q      <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      rnd_q      <= rnd_d;
      cnt_q      <= cnt_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign kg.busy_o     = busy_q;
  assign kg.rk_valid_o = rk_valid_q;
  assign kg.rk_o       = key_q;
  assign kg.rk_rnd_o   = rnd_q;
  assign kg.done_o     = done_q;

endmodule
